// File: rtl/controller_poller.sv
// Polls a serial game-pad (latch + shift clock) at a fixed interval and exposes the
// committed button state, a frame counter and sticky press bits through a small MMIO block.
module controller_poller #(
    parameter int unsigned HALF_PERIOD   = 600,
    parameter int unsigned POLL_INTERVAL = 1666666,
    parameter logic [31:0] BASE_ADDR     = 32'hFFFF0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pad_data,
    output logic        pad_latch,
    output logic        pad_clk,
    input  logic [31:0] address,
    input  logic        readEn,
    output logic [31:0] readData,
    output logic [7:0]  buttons,
    output logic        valid
);

    localparam logic [31:0] HP_LAST    = 32'(HALF_PERIOD - 1);
    localparam logic [31:0] LATCH_LAST = 32'(2 * HALF_PERIOD - 1);
    localparam logic [31:0] POLL_LAST  = 32'(POLL_INTERVAL - 1);
    localparam logic [31:0] ADDR_BTN   = BASE_ADDR;
    localparam logic [31:0] ADDR_FRAME = BASE_ADDR + 32'd4;
    localparam logic [31:0] ADDR_STICK = BASE_ADDR + 32'd8;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LATCH    = 3'd1,
        S_CLK_HIGH = 3'd2,
        S_CLK_LOW  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shadow_q, shadow_d;
    logic [7:0]  buttons_q, buttons_d;
    logic [7:0]  sticky_q, sticky_d;
    logic [31:0] frame_count_q, frame_count_d;
    logic [1:0]  sync_q, sync_d;
    logic        valid_q, valid_d;
    logic        pad_latch_q, pad_latch_d;
    logic        pad_clk_q, pad_clk_d;
    logic        sticky_clr_s;
    logic        pad_s;

    assign pad_s        = sync_q[1];
    assign sticky_clr_s = readEn && (address == ADDR_STICK);

    // Next-state logic for the poll sequencer and every register it owns.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shadow_d      = shadow_q;
        buttons_d     = buttons_q;
        frame_count_d = frame_count_q;
        sync_d        = {sync_q[0], pad_data};
        if (sticky_clr_s) begin
            sticky_d = 8'h00;
        end else begin
            sticky_d = sticky_q;
        end

        case (state_q)
            S_IDLE: begin
                if (cnt_q == POLL_LAST) begin
                    state_d = S_LATCH;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    shadow_d[0] = pad_s;
                    idx_d       = 3'd1;
                    state_d     = S_CLK_HIGH;
                    cnt_d       = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_CLK_HIGH: begin
                if (cnt_q == HP_LAST) begin
                    state_d = S_CLK_LOW;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_CLK_LOW: begin
                if (cnt_q == HP_LAST) begin
                    shadow_d[idx_q] = pad_s;
                    cnt_d           = 32'd0;
                    if (idx_q == 3'd7) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_CLK_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DONE: begin
                // A set in the same cycle as a sticky read-clear takes priority.
                buttons_d     = ~shadow_q;
                frame_count_d = frame_count_q + 32'd1;
                sticky_d      = sticky_d | ~shadow_q;
                idx_d         = 3'd0;
                cnt_d         = 32'd0;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 32'd0;
                idx_d   = 3'd0;
            end
        endcase

        valid_d     = (state_q == S_DONE);
        pad_latch_d = (state_d == S_LATCH);
        pad_clk_d   = (state_d == S_CLK_HIGH);
    end

    // State registers; pad strobes are registered copies of the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= 32'd0;
            idx_q         <= 3'd0;
            shadow_q      <= 8'hFF;
            buttons_q     <= 8'h00;
            sticky_q      <= 8'h00;
            frame_count_q <= 32'd0;
            sync_q        <= 2'b11;
            valid_q       <= 1'b0;
            pad_latch_q   <= 1'b0;
            pad_clk_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            buttons_q     <= buttons_d;
            sticky_q      <= sticky_d;
            frame_count_q <= frame_count_d;
            sync_q        <= sync_d;
            valid_q       <= valid_d;
            pad_latch_q   <= pad_latch_d;
            pad_clk_q     <= pad_clk_d;
        end
    end

    // MMIO read mux; unmapped addresses and idle cycles return zero.
    always_comb begin
        readData = 32'd0;
        if (readEn) begin
            case (address)
                ADDR_BTN:   readData = {24'd0, buttons_q};
                ADDR_FRAME: readData = frame_count_q;
                ADDR_STICK: readData = {24'd0, sticky_q};
                default:    readData = 32'd0;
            endcase
        end else begin
            readData = 32'd0;
        end
    end

    assign pad_latch = pad_latch_q;
    assign pad_clk   = pad_clk_q;
    assign buttons   = buttons_q;
    assign valid     = valid_q;

endmodule

// File: tb/tb_controller_poller.sv
// Scoreboard bench for controller_poller: a pad model shifts out a chosen pattern, the expected
// button byte is queued per poll and compared when valid pulses; MMIO reads are checked inline.
module tb_controller_poller;

    localparam logic [31:0] BASE = 32'hFFFF0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        pad_data = 1'b1;
    logic        pad_latch;
    logic        pad_clk;
    logic [31:0] address;
    logic        readEn;
    logic [31:0] readData;
    logic [7:0]  buttons;
    logic        valid;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  pattern = 8'hFF;
    logic [7:0]  exp_q[$];

    controller_poller #(
        .HALF_PERIOD  (4),
        .POLL_INTERVAL(50),
        .BASE_ADDR    (BASE)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .pad_data (pad_data),
        .pad_latch(pad_latch),
        .pad_clk  (pad_clk),
        .address  (address),
        .readEn   (readEn),
        .readData (readData),
        .buttons  (buttons),
        .valid    (valid)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Pad model plus per-poll waveform measurement and scoreboard pop on valid.
    int         idx = 8;
    int         lat_cnt = 0, clk_hi = 0, pulses = 0, poll_len = 0, overlap = 0;
    logic       prev_latch = 1'b0, prev_clk = 1'b0, prev_valid = 1'b0;
    logic [7:0] exp_b;

    always @(negedge clock) begin
        if (pad_latch && !prev_latch) begin
            idx = 0; lat_cnt = 1; clk_hi = 0; pulses = 0; poll_len = 0; overlap = 0;
        end else begin
            poll_len++;
            if (pad_latch) lat_cnt++;
        end
        if (pad_clk) clk_hi++;
        if (pad_clk && !prev_clk) begin
            pulses++;
            idx++;
        end
        if (pad_latch && pad_clk) overlap++;
        pad_data = (idx < 8) ? pattern[idx[2:0]] : 1'b1;
        if (valid) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_b = exp_q.pop_front();
                check("buttons", {24'd0, buttons}, {24'd0, exp_b});
            end
            check("latch_cycles", lat_cnt, 32'd8);
            check("clk_pulses", pulses, 32'd7);
            check("clk_high_cycles", clk_hi, 32'd28);
            check("poll_length", poll_len, 32'd65);
            check("latch_clk_overlap", overlap, 32'd0);
            check("valid_width", {31'd0, prev_valid}, 32'd0);
        end
        prev_latch = pad_latch;
        prev_clk   = pad_clk;
        prev_valid = valid;
    end

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        address = addr;
        readEn  = 1'b1;
        #1;
        check(tag, readData, exp);
        @(negedge clock);
        readEn = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        @(negedge clock);
        while (!valid && n < 400) begin
            @(negedge clock);
            n++;
        end
        check(tag, {31'd0, valid}, 32'd1);
    endtask

    task automatic wait_latch(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!pad_latch && n < 400);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        reset   = 1'b0;
        readEn  = 1'b0;
        address = 32'd0;
        repeat (3) @(negedge clock);
        check("rst_latch", {31'd0, pad_latch}, 32'd0);
        check("rst_clk", {31'd0, pad_clk}, 32'd0);
        check("rst_buttons", {24'd0, buttons}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        rd("rst_frame", BASE + 32'd4, 32'd0);
        rd("rst_sticky", BASE + 32'd8, 32'd0);

        // Three polls with nothing pressed.
        repeat (3) exp_q.push_back(8'h00);
        reset = 1'b1;
        wait_latch(n);
        check("first_latch_delay", n, 32'd50);
        for (int p = 0; p < 3; p++) wait_valid("idle_poll_done");
        rd("idle_buttons", BASE, 32'd0);
        rd("idle_frame", BASE + 32'd4, 32'd3);
        rd("idle_sticky", BASE + 32'd8, 32'd0);

        // A and Start pressed: serial 0,1,1,0,1,1,1,1.
        pattern = 8'hF6; exp_q.push_back(8'h09);
        wait_valid("a_start_done");
        rd("a_start_buttons", BASE, 32'h09);
        rd("a_start_frame", BASE + 32'd4, 32'd4);
        rd("a_start_sticky", BASE + 32'd8, 32'h09);

        // Bit2 pressed then released; sticky remembers it until read.
        pattern = 8'hFB; exp_q.push_back(8'h04);
        wait_valid("bit2_press_done");
        pattern = 8'hFF; exp_q.push_back(8'h00);
        wait_valid("bit2_release_done");
        rd("sticky_bit2", BASE + 32'd8, 32'h04);
        rd("sticky_bit2_cleared", BASE + 32'd8, 32'h00);

        // Sticky read landing on the DONE cycle of a poll with bit7 newly pressed.
        pattern = 8'hFE; exp_q.push_back(8'h01);
        wait_valid("bit0_done");
        pattern = 8'h7F; exp_q.push_back(8'h80);
        wait_latch(n);
        check("latch_seen", {31'd0, pad_latch}, 32'd1);
        repeat (64) @(negedge clock);
        rd("sticky_on_done", BASE + 32'd8, 32'h01);
        check("done_valid", {31'd0, valid}, 32'd1);
        rd("sticky_after_done", BASE + 32'd8, 32'h80);
        rd("bit7_buttons", BASE, 32'h80);

        // Reset during CLK_LOW of bit 3 aborts the poll.
        pattern = 8'h00;
        wait_latch(n);
        check("latch_seen2", {31'd0, pad_latch}, 32'd1);
        repeat (29) @(negedge clock);
        check("in_clk_low", {31'd0, pad_clk}, 32'd0);
        reset = 1'b0;
        #1;
        check("abort_latch", {31'd0, pad_latch}, 32'd0);
        check("abort_clk", {31'd0, pad_clk}, 32'd0);
        check("abort_buttons", {24'd0, buttons}, 32'd0);
        check("abort_valid", {31'd0, valid}, 32'd0);
        rd("abort_frame", BASE + 32'd4, 32'd0);
        pattern = 8'hFF; exp_q.push_back(8'h00);
        reset = 1'b1;
        wait_latch(n);
        check("relatch_delay", n, 32'd50);
        wait_valid("post_abort_done");
        rd("post_abort_frame", BASE + 32'd4, 32'd1);
        rd("post_abort_sticky", BASE + 32'd8, 32'd0);

        // Frame counter wrap from all-ones.
        force dut.frame_count_q = 32'hFFFFFFFF;
        @(negedge clock);
        release dut.frame_count_q;
        rd("frame_forced", BASE + 32'd4, 32'hFFFFFFFF);
        address = BASE + 32'd4;
        readEn  = 1'b0;
        #1;
        check("no_readen", readData, 32'd0);
        @(negedge clock);
        pattern = 8'hF6; exp_q.push_back(8'h09);
        wait_valid("wrap_done");
        rd("frame_wrap", BASE + 32'd4, 32'd0);
        rd("unmapped_c", BASE + 32'hC, 32'd0);
        rd("wrap_buttons", BASE, 32'h09);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
